square_region_reader: RTL and testbench

- Reader counterpart to the square plotter. The plotter sweeps an 8x8 block and writes pixels; this block sweeps the same 8x8 block and reads pixels back from the on-chip frame-buffer read port.
- Reports whether any pixel differs from a given background colour, and also reports the count and the first such pixel.
- Game logic uses it for collision detection before moving a square.
- Sits between the game FSM (start/done handshake) and the frame-buffer RAM read port.

---
 rtl/square_region_reader_pkg.sv | 26 ++
 rtl/square_region_reader_if.sv | 32 +++
 rtl/square_scan_counter.sv | 40 ++++
 rtl/square_region_reader.sv | 146 ++++++++++++++
 tb/tb_square_region_reader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/square_region_reader_pkg.sv
// Shared types and constants for the square region reader and its scan counter.
// Coordinate/colour widths match the frame buffer; the state encoding is shared with the top.
package square_region_reader_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned XW       = 8;
  localparam int unsigned YW       = 7;
  localparam int unsigned CW       = 3;
  localparam int unsigned HITW     = 7;

  typedef logic [XW-1:0]   xcoord_t;
  typedef logic [YW-1:0]   ycoord_t;
  typedef logic [CW-1:0]   colour_t;
  typedef logic [HITW-1:0] hit_count_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } state_t;

  localparam colour_t BLACK = 3'b000;

endpackage

// File: rtl/square_region_reader_if.sv
// Bundle of the game-FSM handshake, result bus and frame-buffer read port.
// slave is the reader's view; master is the game logic / RAM side.
interface square_region_reader_if;
  import square_region_reader_pkg::*;

  logic       start;
  xcoord_t    X;
  ycoord_t    Y;
  colour_t    bg_colour;
  logic       rd_en;
  xcoord_t    rd_x;
  ycoord_t    rd_y;
  colour_t    rd_colour;
  logic       busy;
  logic       done;
  logic       hit;
  hit_count_t hit_count;
  xcoord_t    first_x;
  ycoord_t    first_y;
  colour_t    first_colour;

  modport slave (
    input  start, X, Y, bg_colour, rd_colour,
    output rd_en, rd_x, rd_y, busy, done, hit, hit_count, first_x, first_y, first_colour
  );

  modport master (
    output start, X, Y, bg_colour, rd_colour,
    input  rd_en, rd_x, rd_y, busy, done, hit, hit_count, first_x, first_y, first_colour
  );

endinterface

// File: rtl/square_scan_counter.sv
// Column-major sweep counter for a 2^SIZE_LOG2 square: high bits step x, low bits step y.
// Shared with the square plotter so both blocks visit pixels in the same order.
module square_scan_counter #(
  parameter int unsigned SIZE_LOG2 = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 step_i,
  output logic [SIZE_LOG2-1:0] x_off_o,
  output logic [SIZE_LOG2-1:0] y_off_o,
  output logic                 last_o
);

  localparam int unsigned CntW = 2 * SIZE_LOG2;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign x_off_o = cnt_q[CntW-1:SIZE_LOG2];
  assign y_off_o = cnt_q[SIZE_LOG2-1:0];
  assign last_o  = &cnt_q;

endmodule

// File: rtl/square_region_reader.sv
// Sweeps a square of the frame buffer and reports non-background pixels (count and first hit).
// Used by the game FSM for collision checks before a square is moved.
module square_region_reader #(
  parameter int unsigned SIZE_LOG2 = 3,
  parameter int unsigned SCREEN_W  = square_region_reader_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H  = square_region_reader_pkg::SCREEN_H,
  parameter int unsigned RD_LAT    = 1
) (
  input logic                   clk,
  input logic                   resetn,
  square_region_reader_if.slave bus
);
  import square_region_reader_pkg::*;

  localparam int unsigned DrW = $clog2(RD_LAT + 1);

  state_t           state_q;
  xcoord_t          x_q;
  ycoord_t          y_q;
  colour_t          bg_q;
  logic [DrW-1:0]   drain_q;
  logic             hit_q;
  hit_count_t       hit_count_q;
  xcoord_t          first_x_q;
  ycoord_t          first_y_q;
  colour_t          first_colour_q;

  logic [SIZE_LOG2-1:0] x_off, y_off;
  logic                 last;
  logic                 scan, accept, on_screen, ret_hit;
  xcoord_t              addr_x;
  ycoord_t              addr_y;

  // Slot tags travel alongside the RAM latency so each return knows its pixel.
  logic [RD_LAT-1:0] pv_q;
  xcoord_t           px_q [RD_LAT];
  ycoord_t           py_q [RD_LAT];

  assign scan   = (state_q == StScan);
  assign accept = (state_q == StIdle) && bus.start;

  square_scan_counter #(
    .SIZE_LOG2 (SIZE_LOG2)
  ) u_counter (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .clear_i (accept),
    .step_i  (scan),
    .x_off_o (x_off),
    .y_off_o (y_off),
    .last_o  (last)
  );

  assign addr_x    = x_q + xcoord_t'(x_off);
  assign addr_y    = y_q + ycoord_t'(y_off);
  assign on_screen = (32'(addr_x) < SCREEN_W) && (32'(addr_y) < SCREEN_H);

  assign bus.rd_en = scan && on_screen;
  assign bus.rd_x  = scan ? addr_x : '0;
  assign bus.rd_y  = scan ? addr_y : '0;

  assign ret_hit = pv_q[RD_LAT-1] && (bus.rd_colour != bg_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= bus.rd_en;
      px_q[0] <= addr_x;
      py_q[0] <= addr_y;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        px_q[i] <= px_q[i-1];
        py_q[i] <= py_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      x_q            <= '0;
      y_q            <= '0;
      bg_q           <= BLACK;
      drain_q        <= '0;
      hit_q          <= 1'b0;
      hit_count_q    <= '0;
      first_x_q      <= '0;
      first_y_q      <= '0;
      first_colour_q <= '0;
    end else begin
      if (ret_hit) begin
        hit_count_q <= hit_count_q + HITW'(1);
        hit_q       <= 1'b1;
        if (!hit_q) begin
          first_x_q      <= px_q[RD_LAT-1];
          first_y_q      <= py_q[RD_LAT-1];
          first_colour_q <= bus.rd_colour;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            x_q            <= bus.X;
            y_q            <= bus.Y;
            bg_q           <= bus.bg_colour;
            hit_q          <= 1'b0;
            hit_count_q    <= '0;
            first_x_q      <= '0;
            first_y_q      <= '0;
            first_colour_q <= '0;
            state_q        <= StScan;
          end
        end
        StScan: begin
          if (last) begin
            drain_q <= '0;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_q == DrW'(RD_LAT - 1)) begin
            state_q <= StDone;
          end else begin
            drain_q <= drain_q + DrW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy         = (state_q == StScan) || (state_q == StDrain);
  assign bus.done         = (state_q == StDone);
  assign bus.hit          = hit_q;
  assign bus.hit_count    = hit_count_q;
  assign bus.first_x      = first_x_q;
  assign bus.first_y      = first_y_q;
  assign bus.first_colour = first_colour_q;

endmodule

// File: tb/tb_square_region_reader.sv
// Directed bench for square_region_reader at RD_LAT=1 and RD_LAT=3 against a frame-buffer model.
// Expected sweep results come from a reference scan of the RAM model, queued at start.
module tb_square_region_reader;
  import square_region_reader_pkg::*;

  typedef struct packed {
    logic       hit;
    logic [6:0] cnt;
    logic [7:0] fx;
    logic [6:0] fy;
    logic [2:0] fc;
    logic [6:0] reads;
  } exp_t;

  typedef struct packed {
    logic       rd_en;
    logic [7:0] rx;
    logic [6:0] ry;
    logic       busy;
    logic       done;
    logic       hit;
    logic [6:0] cnt;
    logic [7:0] fx;
    logic [6:0] fy;
    logic [2:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  logic [2:0] mem [160][120];
  logic [2:0] a_s1 = 3'b111;
  logic [2:0] b_s1 = 3'b111, b_s2 = 3'b111, b_s3 = 3'b111;

  always #5 clk = ~clk;

  square_region_reader_if ia ();
  square_region_reader_if ib ();

  square_region_reader #(.RD_LAT(1)) dut_a (.clk(clk), .resetn(resetn), .bus(ia));
  square_region_reader #(.RD_LAT(3)) dut_b (.clk(clk), .resetn(resetn), .bus(ib));

  // Returns garbage when not strobed so mis-tagged slots show up as hits.
  function automatic logic [2:0] ram_rd(logic en, logic [7:0] x, logic [6:0] y);
    if (en && x < 8'd160 && y < 7'd120) return mem[x][y];
    return 3'b111;
  endfunction

  always @(posedge clk) begin
    a_s1 <= ram_rd(ia.rd_en, ia.rd_x, ia.rd_y);
    b_s1 <= ram_rd(ib.rd_en, ib.rd_x, ib.rd_y);
    b_s2 <= b_s1;
    b_s3 <= b_s2;
  end

  assign ia.rd_colour = a_s1;
  assign ib.rd_colour = b_s3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t get_obs(bit sel);
    obs_t o;
    if (sel) o = {ib.rd_en, ib.rd_x, ib.rd_y, ib.busy, ib.done, ib.hit, ib.hit_count,
                  ib.first_x, ib.first_y, ib.first_colour};
    else     o = {ia.rd_en, ia.rd_x, ia.rd_y, ia.busy, ia.done, ia.hit, ia.hit_count,
                  ia.first_x, ia.first_y, ia.first_colour};
    return o;
  endfunction

  task automatic set_start(bit sel, logic v);
    if (sel) ib.start = v;
    else     ia.start = v;
  endtask

  task automatic set_in(bit sel, logic [7:0] x, logic [6:0] y, logic [2:0] bg);
    if (sel) begin ib.X = x; ib.Y = y; ib.bg_colour = bg; end
    else     begin ia.X = x; ia.Y = y; ia.bg_colour = bg; end
  endtask

  task automatic fill(logic [2:0] c);
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) mem[x][y] = c;
  endtask

  function automatic exp_t model(logic [7:0] x0, logic [6:0] y0, logic [2:0] bg);
    exp_t e = '0;
    for (int c = 0; c < 64; c++) begin
      logic [7:0] x = x0 + 8'(c / 8);
      logic [6:0] y = y0 + 7'(c % 8);
      if (x < 8'd160 && y < 7'd120) begin
        e.reads++;
        if (mem[x][y] != bg) begin
          if (!e.hit) begin e.fx = x; e.fy = y; e.fc = mem[x][y]; end
          e.hit = 1'b1;
          e.cnt++;
        end
      end
    end
    return e;
  endfunction

  // Entered #1 after an edge with the selected DUT idle; cycle k is the one after edge Ek.
  task automatic sweep(input bit sel, input logic [7:0] x0, input logic [6:0] y0,
                       input logic [2:0] bg, input bit poke_mid, input bit poke_done,
                       input string name);
    int   lat = sel ? 3 : 1;
    int   reads = 0, done_cnt = 0, done_at = -1, addr_err = 0;
    obs_t o;
    exp_t e;
    set_in(sel, x0, y0, bg);
    set_start(sel, 1'b1);
    sb_q.push_back(model(x0, y0, bg));
    for (int k = 0; k < 64 + lat + 4; k++) begin
      @(posedge clk);
      #1;
      o = get_obs(sel);
      if (k == 0) begin
        set_start(sel, 1'b0);
        set_in(sel, x0 + 8'd40, y0 + 7'd9, ~bg);
        chk({name, "_busy_e0"}, 32'(o.busy), 1);
      end
      if (k < 64) begin
        logic [7:0] ex = x0 + 8'(k / 8);
        logic [6:0] ey = y0 + 7'(k % 8);
        logic       een = (ex < 8'd160) && (ey < 7'd120);
        if (o.rd_en !== een || o.rx !== ex || o.ry !== ey) addr_err++;
      end else if (o.rd_en) begin
        addr_err++;
      end
      if (o.rd_en) reads++;
      if (poke_mid && k == 30) set_start(sel, 1'b1);
      if (poke_mid && k == 31) set_start(sel, 1'b0);
      if (poke_done && done_at >= 0 && k == done_at + 1) set_start(sel, 1'b0);
      if (o.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          chk({name, "_busy_at_done"}, 32'(o.busy), 0);
          if (poke_done) set_start(sel, 1'b1);
        end
      end
    end
    set_start(sel, 1'b0);
    e = sb_q.pop_front();
    o = get_obs(sel);
    chk({name, "_done_cycle"}, 32'(done_at), 32'(64 + lat));
    chk({name, "_done_pulses"}, 32'(done_cnt), 1);
    chk({name, "_addr_errs"}, 32'(addr_err), 0);
    chk({name, "_reads"}, 32'(reads), 32'(e.reads));
    chk({name, "_idle_after"}, 32'(o.busy), 0);
    chk({name, "_hit"}, 32'(o.hit), 32'(e.hit));
    chk({name, "_hit_count"}, 32'(o.cnt), 32'(e.cnt));
    chk({name, "_first_x"}, 32'(o.fx), 32'(e.fx));
    chk({name, "_first_y"}, 32'(o.fy), 32'(e.fy));
    chk({name, "_first_colour"}, 32'(o.fc), 32'(e.fc));
  endtask

  initial begin
    obs_t o;
    resetn = 1'b0;
    ia.start = 1'b0;
    ib.start = 1'b0;
    set_in(0, 8'd0, 7'd0, 3'd0);
    set_in(1, 8'd0, 7'd0, 3'd0);
    fill(3'd0);
    repeat (2) @(posedge clk);
    #1;
    o = get_obs(0);
    chk("reset_outputs", 32'({o.rd_en, o.busy, o.done, o.hit, o.cnt, o.fx, o.fy, o.fc}), 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    sweep(0, 8'd10, 7'd20, 3'd0, 0, 0, "all_bg");
    chk("all_bg_expect_reads", 32'(model(8'd10, 7'd20, 3'd0).reads), 64);

    mem[13][22] = 3'b100;
    sweep(0, 8'd10, 7'd20, 3'd0, 0, 0, "single");

    fill(3'd0);
    mem[11][25] = 3'b010;
    mem[12][20] = 3'b010;
    sweep(0, 8'd10, 7'd20, 3'd0, 1, 0, "order_mid_start");
    sweep(0, 8'd10, 7'd20, 3'd0, 0, 1, "order_done_start");

    fill(3'd7);
    sweep(0, 8'd156, 7'd116, 3'd0, 0, 0, "clip");

    fill(3'd0);
    mem[11][25] = 3'b010;
    mem[12][20] = 3'b010;
    sweep(1, 8'd10, 7'd20, 3'd0, 1, 1, "lat3_order");
    fill(3'd7);
    sweep(1, 8'd156, 7'd116, 3'd0, 0, 0, "lat3_clip");

    // Abort a sweep with reset at cycle 40, then verify a clean rerun.
    fill(3'd0);
    mem[11][25] = 3'b101;
    set_in(0, 8'd10, 7'd20, 3'd0);
    set_start(0, 1'b1);
    @(posedge clk);
    #1;
    set_start(0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    o = get_obs(0);
    chk("pre_reset_busy", 32'(o.busy), 1);
    chk("pre_reset_hit", 32'(o.hit), 1);
    resetn = 1'b0;
    #1;
    o = get_obs(0);
    chk("async_reset_outputs",
        32'({o.rd_en, o.rx, o.ry, o.busy, o.done, o.hit, o.cnt}), 0);
    chk("async_reset_first", 32'({o.fx, o.fy, o.fc}), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      o = get_obs(0);
      chk("in_reset_quiet", 32'({o.done, o.busy, o.rd_en}), 0);
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
    o = get_obs(0);
    chk("post_reset_no_done", 32'(o.done), 0);
    sweep(0, 8'd10, 7'd20, 3'd0, 0, 0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
